svm_weight_loader: RTL and testbench



---
 rtl/svm_weight_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_svm_weight_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/svm_weight_loader.sv
// -----------------------------------------------------------------------------
// svm_weight_loader
//
// Writer side of the SVM weight/bias store. Takes a framed byte stream
// (SOF, ROWS*COLS little-endian 32-bit words, XOR checksum byte). It packs the
// bytes into words and writes them row-major into a ROWS x COLS register array.
// The SVM datapath reads the array through an asynchronous port. The checksum
// result drives weights_valid, which the SVM controller uses as its inference
// enable.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   s_data        stream byte
//   s_valid       s_data valid
//   s_ready       loader can accept a byte (transfer = s_valid && s_ready)
//   rd_row        read row index
//   rd_col        read column index
//   rd_data       combinational read of weight[rd_row][rd_col], 0 if out of range
//   weights_valid array holds a checksum-verified frame
//   load_busy     frame reception in progress (PAYLOAD or CHECK)
//   load_err      last frame failed its checksum
//   words_loaded  words written in the current or last frame
// -----------------------------------------------------------------------------
module svm_weight_loader #(
    parameter int          ROWS = 6,
    parameter int          COLS = 6,
    parameter logic [7:0]  SOF  = 8'hA5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [$clog2(ROWS)-1:0]            rd_row,
    input  logic [$clog2(COLS)-1:0]            rd_col,
    output logic [31:0]                        rd_data,
    output logic                               weights_valid,
    output logic                               load_busy,
    output logic                               load_err,
    output logic [$clog2(ROWS*COLS+1)-1:0]     words_loaded
);

    localparam int N_WORDS = ROWS * COLS;
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int WLW     = $clog2(N_WORDS + 1);

    localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
    localparam logic [WLW-1:0] WL_LAST = WLW'(N_WORDS - 1);
    localparam logic [WLW-1:0] WL_FULL = WLW'(N_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // Weight/bias storage and frame bookkeeping
    logic [31:0]    r_mem [ROWS][COLS];
    logic [31:0]    r_asm;
    logic [7:0]     r_csum;
    logic [1:0]     r_bcnt;
    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [WLW-1:0] r_words;
    logic           r_wv;
    logic           r_err;

    logic           w_fire;
    logic           w_is_sof;
    logic           w_word_done;
    logic           w_last_word;
    logic           w_rd_ok;
    logic [31:0]    w_word;

    assign w_fire      = s_valid & s_ready;
    assign w_is_sof    = (s_data == SOF);
    assign w_word_done = (r_bcnt == 2'd3);
    assign w_last_word = (r_words == WL_LAST);

    // Bytes shift in from the top, so after four bytes the first one sits in
    // the LSB. The completed word uses the incoming byte directly, so the
    // array write lands on the same edge that accepts byte 3.
    assign w_word = {s_data, r_asm[31:8]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b1;
        load_busy   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire && w_is_sof) begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                load_busy = 1'b1;
                if (w_fire && w_word_done && w_last_word) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                load_busy = 1'b1;
                if (w_fire) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // One dead cycle so the controller sees the final flags
                // before another SOF can clear them.
                s_ready     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: assembly, checksum, counters, array writes, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
            r_asm   <= '0;
            r_csum  <= '0;
            r_bcnt  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_words <= '0;
            r_wv    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Non-SOF bytes are consumed and dropped here.
                    if (w_fire && w_is_sof) begin
                        r_wv    <= 1'b0;
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_csum  <= '0;
                        r_bcnt  <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_asm   <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    // SOF-valued bytes are plain data in this state.
                    if (w_fire) begin
                        r_csum <= r_csum ^ s_data;
                        r_asm  <= w_word;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_word_done) begin
                            r_mem[r_row][r_col] <= w_word;
                            if (r_words != WL_FULL) begin
                                r_words <= r_words + 1'b1;
                            end
                            // Row/col counters walk row-major alongside the
                            // word count, avoiding a divider on w.
                            if (r_col == COL_MAX) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    // Flags are registered here so they are already visible
                    // during the COMMIT cycle.
                    if (w_fire) begin
                        if (s_data == r_csum) begin
                            r_wv <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Asynchronous read port. Indices past the array return zero.
    // ------------------------------------------------------------------
    assign w_rd_ok = (rd_row <= ROW_MAX) && (rd_col <= COL_MAX);
    assign rd_data = w_rd_ok ? r_mem[rd_row][rd_col] : 32'd0;

    assign weights_valid = r_wv;
    assign load_err      = r_err;
    assign words_loaded  = r_words;

endmodule

// File: tb/tb_svm_weight_loader.sv
module tb_svm_weight_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic [31:0] rd_data;
    logic        weights_valid;
    logic        load_busy;
    logic        load_err;
    logic [5:0]  words_loaded;

    int tot = 0;
    int bad = 0;

    svm_weight_loader #(.ROWS(6), .COLS(6), .SOF(8'hA5)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .weights_valid(weights_valid),
        .load_busy(load_busy), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos: -1 waiting for SOF, 0..143 payload byte index, 144 checksum, 145 commit
    int          pos = -1;
    logic [31:0] m_mem [36];
    logic        m_wv = 1'b0;
    logic        m_err = 1'b0;
    int          m_wl = 0;
    logic [7:0]  pl[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos = -1; m_wv = 1'b0; m_err = 1'b0; m_wl = 0; pl.delete();
            for (int i = 0; i < 36; i++) m_mem[i] = 32'd0;
        end else if (pos == 145) begin
            pos = -1;
        end else if (s_valid) begin
            if (pos == -1) begin
                if (s_data == 8'hA5) begin
                    m_wv = 1'b0; m_err = 1'b0; m_wl = 0; pl.delete(); pos = 0;
                end
            end else if (pos < 144) begin
                pl.push_back(s_data);
                if (pl.size() % 4 == 0) begin
                    int n;
                    n = pl.size();
                    m_mem[n/4 - 1] = {pl[n-1], pl[n-2], pl[n-3], pl[n-4]};
                    m_wl++;
                end
                pos++;
            end else begin
                logic [7:0] x;
                x = 8'h00;
                foreach (pl[i]) x ^= pl[i];
                if (s_data == x) m_wv = 1'b1; else m_err = 1'b1;
                pos = 145;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] r, input logic [2:0] c);
        if (r < 3'd6 && c < 3'd6) return m_mem[int'(r) * 6 + int'(c)];
        return 32'd0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("s_ready",       32'(s_ready),       32'(pos != 145));
        chk("load_busy",     32'(load_busy),     32'(pos >= 0 && pos <= 144));
        chk("weights_valid", 32'(weights_valid), 32'(m_wv));
        chk("load_err",      32'(load_err),      32'(m_err));
        chk("words_loaded",  32'(words_loaded),  32'(m_wl));
        chk("rd_data",       rd_data,            exp_rd(rd_row, rd_col));
    end

    // ---------------- stimulus ----------------
    logic [31:0] fw [36];

    task automatic send(input logic [7:0] b, input int gmode);
        int   n;
        logic acc;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        rd_row  = 3'($urandom_range(0, 7));
        rd_col  = 3'($urandom_range(0, 7));
        do begin
            acc = s_ready;
            @(posedge clk); #2;
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) == 0)) begin
            s_valid = 1'b0;
            @(posedge clk); #2;
        end
    endtask

    // Ends at the COMMIT cycle (posedge+2 after the checksum byte is taken).
    task automatic send_frame(input bit badck, input int gmode);
        logic [7:0] ck;
        logic [7:0] b;
        logic [31:0] w;
        ck = 8'h00;
        send(8'hA5, gmode);
        chk("busy_after_sof", 32'(load_busy), 32'd1);
        for (int i = 0; i < 36; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                ck ^= b;
                send(b, gmode);
            end
        end
        send(ck ^ {7'd0, badck}, 0);
        s_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int r, input int c, input logic [31:0] exp);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; rd_row = 3'd0; rd_col = 3'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_wv", 32'(weights_valid), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        @(posedge clk); #2;

        // Idle garbage, then a clean frame of 3F800000 + w
        send(8'h00, 0); send(8'h13, 0); send(8'hFF, 0);
        s_valid = 1'b0;
        chk("idle_not_busy", 32'(load_busy), 32'd0);
        for (int i = 0; i < 36; i++) fw[i] = 32'h3F800000 + 32'(i);
        send_frame(1'b0, 0);
        chk("good_commit_ready", 32'(s_ready), 32'd0);
        chk("good_wv", 32'(weights_valid), 32'd1);
        chk("good_err", 32'(load_err), 32'd0);
        chk("good_wl", 32'(words_loaded), 32'd36);
        rd_chk("good_rd23", 2, 3, 32'h3F80000F);
        rd_chk("good_rd55", 5, 5, 32'h3F800023);
        rd_chk("good_rd_oob", 6, 0, 32'h0);
        @(posedge clk); #2;

        // Same frame with a corrupted checksum
        send_frame(1'b1, 0);
        chk("bad_wv", 32'(weights_valid), 32'd0);
        chk("bad_err", 32'(load_err), 32'd1);
        rd_chk("bad_rd01", 0, 1, 32'h3F800001);
        @(posedge clk); #2;

        // Gapped stream, s_valid alternating
        send_frame(1'b0, 1);
        chk("gap_wv", 32'(weights_valid), 32'd1);
        chk("gap_err", 32'(load_err), 32'd0);
        chk("gap_wl", 32'(words_loaded), 32'd36);
        @(posedge clk); #2;

        // Random payload with SOF-valued bytes embedded, random gaps
        for (int i = 0; i < 36; i++) fw[i] = $urandom;
        fw[0] = 32'hA5A5A5A5;
        fw[7] = 32'h12A5A5A5;
        send_frame(1'b0, 2);
        chk("rnd_wv", 32'(weights_valid), 32'd1);
        rd_chk("rnd_sof_w0", 0, 0, 32'hA5A5A5A5);
        rd_chk("rnd_sof_w7", 1, 1, 32'h12A5A5A5);
        @(posedge clk); #2;

        // Reset mid-frame after 50 payload bytes
        send(8'hA5, 0);
        for (int i = 0; i < 50; i++) send(8'($urandom), 0);
        s_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wl", 32'(words_loaded), 32'd0);
        chk("mid_rst_busy", 32'(load_busy), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rd_chk("mid_rst_zero", r, c, 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 36; i++) fw[i] = 32'h3F800000 + 32'(i);
        send_frame(1'b0, 0);
        chk("after_rst_wv", 32'(weights_valid), 32'd1);
        rd_chk("after_rst_rd55", 5, 5, 32'h3F800023);

        repeat (4) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
